uart_tx_engine: RTL and testbench

Serial transmit back-end downstream of the UART register file. It consumes bytes written to THR (address 0) and buffers them in a small FIFO. Each byte is serialized onto the TX pin as a 16550-style asynchronous frame, with format taken from LCR and bit rate taken from the divisor latch. It returns THR-empty and TX-empty status to the register file for LSR bits 5 and 6.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_tx_fifo.sv | 78 +++++++
 rtl/uart_tx_engine.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_engine.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path and the register file:
//   - tx_state_e : transmit FSM state encoding
//   - LCR_*      : bit positions inside the line control register
//   - OVERSAMPLE : baud ticks per serial bit time
//   - ADDR_*     : register addresses shared with the register file
//   - tx_parity(): parity bit for a character of 5..8 bits
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    // LCR bit positions; word length occupies [LCR_WLS+1:LCR_WLS]
    localparam int LCR_WLS = 0;
    localparam int LCR_STB = 2;
    localparam int LCR_PEN = 3;
    localparam int LCR_EPS = 4;
    localparam int LCR_BRK = 6;

    // Register file addresses
    localparam logic [2:0] ADDR_THR = 3'd0;
    localparam logic [2:0] ADDR_LCR = 3'd3;
    localparam logic [2:0] ADDR_LSR = 3'd5;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_e;

    // Parity over the low 5+wls bits; odd parity inverts the XOR.
    function automatic logic tx_parity(input logic [7:0] data,
                                       input logic [1:0] wls,
                                       input logic       even);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - wls);
        return (^(data & mask)) ^ ~even;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Synchronous FIFO holding bytes waiting for the transmit shifter.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_data : write strobe and data (ignored when full or clearing)
//   i_pop, o_data  : read strobe and head-of-queue data (show-ahead)
//   i_clear        : synchronous flush, wins over push and pop
//   o_full, o_empty, o_count : occupancy status
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    input  logic                       i_clear,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == {CW{1'b0}});
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // A full FIFO rejects writes even if a pop frees a slot on that edge.
    assign w_push = i_push && !o_full && !i_clear;
    assign w_pop  = i_pop && !o_empty && !i_clear;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else if (i_clear) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_engine.sv
// -----------------------------------------------------------------------------
// uart_tx_engine
// UART transmit back-end: buffers THR writes in a FIFO and serializes each
// byte as an asynchronous frame (start, 5..8 data LSB first, optional parity,
// 1 or 2 stop bits). Bit time = OVERSAMPLE * max(i_divisor,1) clocks.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_data, i_valid    : THR write byte and strobe
//   o_ready            : FIFO not full
//   i_lcr              : [1:0] word length, [2] stop bits, [3] parity enable,
//                        [4] even parity, [6] break, [5] unused
//   i_divisor          : baud divisor (0 behaves as 1)
//   i_fifo_clear       : flush TX FIFO (frame in the shifter still completes)
//   o_tx               : serial line, idle high
//   o_thr_empty        : LSR[5], FIFO empty
//   o_tx_empty         : LSR[6], FIFO empty and shifter idle
//   o_overrun          : one-cycle pulse when a write hits a full FIFO
// Build option: define UART_TX_SIM_PRINT_EN to echo each popped byte to the
// simulation console with $write; leave it undefined for synthesis builds.
// -----------------------------------------------------------------------------
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_data,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [6:0]       i_lcr,
    input  logic [DIV_W-1:0] i_divisor,
    input  logic             i_fifo_clear,
    output logic             o_tx,
    output logic             o_thr_empty,
    output logic             o_tx_empty,
    output logic             o_overrun
);
    localparam int TCW = $clog2(OVERSAMPLE);

    logic [7:0]                   w_fifo_data;
    logic                         w_full;
    logic                         w_empty;
    logic [$clog2(FIFO_DEPTH):0]  w_count_unused;
    logic                         w_lcr_unused;
    logic                         w_pop;
    logic                         w_tick;
    logic                         w_bit_done;
    logic                         w_frame_end;
    logic                         w_last_data;
    logic [DIV_W-1:0]             w_reload;

    tx_state_e        r_state;
    logic [DIV_W-1:0] r_baud_cnt;
    logic [TCW-1:0]   r_tick_cnt;
    logic [2:0]       r_bit_idx;
    logic             r_stop_idx;
    logic [7:0]       r_shift;
    logic [1:0]       r_wls;
    logic             r_stb;
    logic             r_pen;
    logic             r_par;
    logic             r_tx;
    logic             r_thr_empty;
    logic             r_tx_empty;
    logic             r_overrun;

    assign w_lcr_unused = i_lcr[5];

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (i_valid),
        .i_data  (i_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .i_clear (i_fifo_clear),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count_unused)
    );

    assign o_ready = !w_full;

    // Baud tick and bit-boundary decode
    assign w_reload    = (i_divisor == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : (i_divisor - DIV_W'(1));
    assign w_tick      = (r_baud_cnt == {DIV_W{1'b0}});
    assign w_bit_done  = w_tick && (r_tick_cnt == TCW'(OVERSAMPLE - 1));
    // Last data bit index is 4+wls, i.e. {1, wls}
    assign w_last_data = (r_bit_idx == {1'b1, r_wls});
    assign w_frame_end = (r_state == TX_STOP) && w_bit_done && (r_stop_idx == r_stb);
    assign w_pop       = !w_empty && ((r_state == TX_IDLE) || w_frame_end);

    // Break overrides the line without disturbing the FSM.
    assign o_tx        = r_tx & ~i_lcr[LCR_BRK];
    assign o_thr_empty = r_thr_empty;
    assign o_tx_empty  = r_tx_empty;
    assign o_overrun   = r_overrun;

    // Baud divider and oversample counter; both restart on every pop.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_baud_cnt <= {DIV_W{1'b0}};
            r_tick_cnt <= {TCW{1'b0}};
        end else if (w_pop) begin
            r_baud_cnt <= w_reload;
            r_tick_cnt <= {TCW{1'b0}};
        end else if (w_tick) begin
            r_baud_cnt <= w_reload;
            r_tick_cnt <= r_tick_cnt + TCW'(1);
        end else begin
            r_baud_cnt <= r_baud_cnt - DIV_W'(1);
        end
    end

    // Transmit FSM; r_tx follows the state one clock later.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= TX_IDLE;
            r_bit_idx  <= 3'd0;
            r_stop_idx <= 1'b0;
            r_shift    <= 8'd0;
            r_wls      <= 2'd0;
            r_stb      <= 1'b0;
            r_pen      <= 1'b0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            // Frame format is captured at pop so later LCR writes wait for the next byte.
            if (w_pop) begin
                r_shift <= w_fifo_data;
                r_wls   <= i_lcr[LCR_WLS +: 2];
                r_stb   <= i_lcr[LCR_STB];
                r_pen   <= i_lcr[LCR_PEN];
                r_par   <= tx_parity(w_fifo_data, i_lcr[LCR_WLS +: 2], i_lcr[LCR_EPS]);
            end
            case (r_state)
                TX_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_state <= TX_START;
                    end else begin
                        r_state <= TX_IDLE;
                    end
                end
                TX_START: begin
                    r_tx <= 1'b0;
                    if (w_bit_done) begin
                        r_state   <= TX_DATA;
                        r_bit_idx <= 3'd0;
                    end
                end
                TX_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_bit_done) begin
                        if (w_last_data) begin
                            r_state    <= r_pen ? TX_PARITY : TX_STOP;
                            r_stop_idx <= 1'b0;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                TX_PARITY: begin
                    r_tx <= r_par;
                    if (w_bit_done) begin
                        r_state    <= TX_STOP;
                        r_stop_idx <= 1'b0;
                    end
                end
                TX_STOP: begin
                    r_tx <= 1'b1;
                    if (w_frame_end) begin
                        r_state <= w_empty ? TX_IDLE : TX_START;
                    end else if (w_bit_done) begin
                        r_stop_idx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= TX_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    // LSR status and overrun pulse; a clear swallows a simultaneous write silently.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_thr_empty <= 1'b1;
            r_tx_empty  <= 1'b1;
            r_overrun   <= 1'b0;
        end else begin
            r_thr_empty <= w_empty;
            r_tx_empty  <= w_empty && (r_state == TX_IDLE);
            r_overrun   <= i_valid && w_full && !i_fifo_clear;
        end
    end

`ifdef UART_TX_SIM_PRINT_EN
    // Console echo of each byte as it leaves the FIFO.
    always_ff @(posedge i_clk) begin
        if (w_pop) begin
            $write("%c", w_fifo_data);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_engine.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_engine
// Scoreboard bench: each accepted byte is queued with the LCR/divisor it will
// be sent with; an independent line monitor decodes every frame on o_tx and
// compares it, clock by clock, against the frame expected from the UART
// framing rules. Directed checks cover latency, status, overrun, clear,
// reset and break.
// -----------------------------------------------------------------------------
module tb_uart_tx_engine;

    typedef struct {
        logic [7:0] data;
        logic [6:0] lcr;
        int         div;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  data;
    logic        valid;
    logic        ready;
    logic [6:0]  lcr;
    logic [15:0] divisor;
    logic        fclr;
    logic        tx;
    logic        thr_empty;
    logic        tx_empty;
    logic        overrun;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b1;
    bit   mon_busy = 1'b0;
    exp_t sb[$];
    int   starts[$];

    uart_tx_engine #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_valid      (valid),
        .o_ready      (ready),
        .i_lcr        (lcr),
        .i_divisor    (divisor),
        .i_fifo_clear (fclr),
        .o_tx         (tx),
        .o_thr_empty  (thr_empty),
        .o_tx_empty   (tx_empty),
        .o_overrun    (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference frame: start, N data LSB first, optional parity, stop bits.
    function automatic int frame_bits(input exp_t e, output logic [11:0] bits);
        int   n;
        int   pos;
        logic x;
        n    = 5 + int'(e.lcr[1:0]);
        bits = 12'hFFF;
        bits[0] = 1'b0;
        x   = 1'b0;
        pos = 1;
        for (int i = 0; i < n; i++) begin
            bits[pos] = e.data[i];
            x = x ^ e.data[i];
            pos++;
        end
        if (e.lcr[3]) begin
            bits[pos] = e.lcr[4] ? x : ~x;
            pos++;
        end
        bits[pos] = 1'b1;
        pos++;
        if (e.lcr[2]) begin
            bits[pos] = 1'b1;
            pos++;
        end
        return pos;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b, input bit expect_it);
        exp_t e;
        data  = b;
        valid = 1'b1;
        tick();
        valid = 1'b0;
        if (expect_it) begin
            e.data = b;
            e.lcr  = lcr;
            e.div  = int'(divisor);
            sb.push_back(e);
        end
    endtask

    // Wait until every queued frame has been seen and the engine reports idle.
    task automatic drain(input string name);
        int n;
        n = 0;
        while (!(sb.size() == 0 && !mon_busy && tx_empty) && n < 20000) begin
            tick();
            n++;
        end
        chk(name, int'(sb.size() == 0 && !mon_busy && tx_empty), 1);
    endtask

    // Line monitor: decodes each frame and compares against the scoreboard head.
    initial begin : monitor
        exp_t        e;
        logic [11:0] bits;
        int          nb;
        int          bt;
        int          wrong;
        forever begin
            @(negedge clk);
            if (mon_en && rst_n && (tx == 1'b0)) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_frame: tx low at cycle %0d, expected idle line", cyc);
                    while (tx == 1'b0) @(negedge clk);
                end else begin
                    mon_busy = 1'b1;
                    e  = sb.pop_front();
                    nb = frame_bits(e, bits);
                    bt = 16 * ((e.div == 0) ? 1 : e.div);
                    starts.push_back(cyc);
                    for (int k = 0; k < nb; k++) begin
                        wrong = 0;
                        for (int j = 0; j < bt; j++) begin
                            if (k != 0 || j != 0) @(negedge clk);
                            if (tx !== bits[k]) wrong++;
                        end
                        n_tests++;
                        if (wrong != 0) begin
                            n_fail++;
                            $display("FAIL frame_bit data=%02h lcr=%02h bit=%0d: %0d of %0d clocks wrong, expected level %b",
                                     e.data, e.lcr, k, wrong, bt, bits[k]);
                        end
                    end
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : stimulus
        bit         bad;
        int         k;
        logic [6:0] la;
        logic [6:0] lb;
        rst_n   = 1'b0;
        data    = 8'd0;
        valid   = 1'b0;
        lcr     = 7'h03;
        divisor = 16'd1;
        fclr    = 1'b0;

        // Reset values
        #12;
        chk("rst_tx", int'(tx), 1);
        chk("rst_ready", int'(ready), 1);
        chk("rst_thr_empty", int'(thr_empty), 1);
        chk("rst_tx_empty", int'(tx_empty), 1);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;
        repeat (3) tick();

        // 8N1, divisor 1, 0x55: latency and end-of-frame status
        wr(8'h55, 1'b1);
        @(negedge clk); chk("lat_edge0_tx", int'(tx), 1);
        tick(); @(negedge clk); chk("lat_edge1_tx", int'(tx), 1);
        tick(); @(negedge clk); chk("lat_edge2_tx", int'(tx), 0);
        repeat (159) @(posedge clk);
        @(negedge clk); chk("tx_empty_before_end", int'(tx_empty), 0);
        @(posedge clk);
        @(negedge clk); chk("tx_empty_after_stop", int'(tx_empty), 1);
        drain("drain_8n1");

        // 7E1, divisor 2, 0x41
        lcr = 7'h1A; divisor = 16'd2; tick();
        wr(8'h41, 1'b1);
        drain("drain_7e1");

        // FIFO fill while a frame is in flight, then overrun
        lcr = 7'h03; divisor = 16'd1; tick();
        starts.delete();
        wr(8'hA5, 1'b1);
        repeat (4) tick();
        for (int i = 0; i < 17; i++) begin
            exp_t e;
            data  = 8'(i * 7 + 3);
            valid = 1'b1;
            if (i < 16) begin
                e.data = data; e.lcr = lcr; e.div = int'(divisor);
                sb.push_back(e);
            end
            tick();
            if (i == 14) chk("ready_at_15", int'(ready), 1);
            if (i == 15) begin
                chk("ready_full", int'(ready), 0);
                chk("overrun_before_drop", int'(overrun), 0);
            end
            if (i == 16) chk("overrun_pulse", int'(overrun), 1);
        end
        valid = 1'b0;
        tick();
        chk("overrun_one_cycle", int'(overrun), 0);
        drain("drain_full");
        chk("full_frames", starts.size(), 17);
        for (int i = 0; i + 1 < starts.size(); i++) begin
            chk("back_to_back_gap", starts[i+1] - starts[i], 160);
        end

        // Queue 4, clear during the first frame (simultaneous write discarded)
        starts.delete();
        wr(8'h31, 1'b1);
        wr(8'h32, 1'b0);
        wr(8'h33, 1'b0);
        wr(8'h34, 1'b0);
        repeat (20) tick();
        fclr = 1'b1; valid = 1'b1; data = 8'h77;
        tick();
        fclr = 1'b0; valid = 1'b0;
        chk("clr_thr_empty_lag", int'(thr_empty), 0);
        tick();
        chk("clr_thr_empty", int'(thr_empty), 1);
        drain("drain_clear");
        bad = 1'b0;
        repeat (200) begin @(negedge clk); if (tx !== 1'b1) bad = 1'b1; end
        chk("clr_idle_after", int'(bad), 0);
        chk("clr_frames", starts.size(), 1);

        // Reset mid data bit 3 of 0x00
        mon_en = 1'b0;
        wr(8'h00, 1'b0);
        repeat (70) tick();
        chk("pre_rst_low", int'(tx), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_tx", int'(tx), 1);
        chk("rst_async_thr_empty", int'(thr_empty), 1);
        chk("rst_async_tx_empty", int'(tx_empty), 1);
        chk("rst_async_ready", int'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (300) begin @(negedge clk); if (tx !== 1'b1) bad = 1'b1; end
        chk("rst_no_frame", int'(bad), 0);
        chk("rst_tx_empty_after", int'(tx_empty), 1);

        // Break while idle
        tick();
        lcr = 7'h43;
        #1 chk("brk_low", int'(tx), 0);
        bad = 1'b0;
        repeat (20) begin @(negedge clk); if (tx !== 1'b0) bad = 1'b1; end
        chk("brk_hold", int'(bad), 0);
        #2 lcr = 7'h03;
        #1 chk("brk_release", int'(tx), 1);
        tick();
        mon_en = 1'b1;

        // Random formats, divisors and bursts; LCR changes while first frame runs
        for (int r = 0; r < 6; r++) begin
            divisor = 16'($urandom_range(0, 3));
            la = 7'($urandom_range(0, 63));
            lcr = la;
            tick();
            wr(8'($urandom), 1'b1);
            repeat (3) tick();
            lb = 7'($urandom_range(0, 63));
            lcr = lb;
            k = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) wr(8'($urandom), 1'b1);
            drain("drain_random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
